// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator for the 64 x 32-bit DataMem array.
// Takes one RV32 load/store at a time, drives the memory strobes and the
// word address, and returns a one-cycle response pulse with load data or
// a fault flag. Sub-word stores use a read-modify-write sequence.
//
// Build option: define LSU_MISALIGN_FAULT_EN to make misaligned halfword
// and word accesses fault. Without it, the offending low address bits are
// ignored and the access proceeds aligned.
//
// Handshake: a request is taken on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE. rsp_valid is a
// single-cycle pulse. rsp_fault qualifies it and is 0 at all other times.
// The FSM state is held in state_q (type state_t) so checkers can bind to it.
module lsu_mem_master (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [5:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STORE  = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic        illegal;
  logic        misalign;
  logic        req_fault;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign rsp_rdata = rdata_q;

  // Classify the incoming request: illegal encodings and, optionally, misalignment.
  always_comb begin
    illegal  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
               (req_we && req_funct3[2]);
`ifdef LSU_MISALIGN_FAULT_EN
    misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    req_fault = illegal || misalign;
  end

  // Pick the addressed lane out of the memory word and extend it for the load result.
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (addr_q[1:0])
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_data = {24'd0, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = mem_rdata;
    endcase
  end

  // Replace the target byte/halfword lane of the registered word, keeping the rest.
  always_comb begin
    merged = word_q;
    if (f3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end
  end

  // Next-state and output logic for the request/memory/response sequence.
  always_comb begin
    state_d   = state_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    word_d    = word_q;
    rdata_d   = rdata_q;
    fault_d   = fault_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_fault = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 6'd0;
    mem_wdata = 32'd0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          fault_d = req_fault;
          if (req_fault) begin
            rdata_d = 32'd0;
            state_d = S_RESP;
          end else if (!req_we) begin
            state_d = S_LOAD;
          end else if (req_funct3 == 3'b010) begin
            state_d = S_STORE;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_LOAD: begin
        mem_rd    = 1'b1;
        mem_addr  = addr_q[7:2];
        mem_wdata = wdata_q;
        rdata_d   = load_data;
        state_d   = S_RESP;
      end
      S_STORE: begin
        mem_wr    = 1'b1;
        mem_addr  = addr_q[7:2];
        mem_wdata = wdata_q;
        rdata_d   = 32'd0;
        state_d   = S_RESP;
      end
      S_RMW_RD: begin
        mem_rd    = 1'b1;
        mem_addr  = addr_q[7:2];
        mem_wdata = wdata_q;
        word_d    = mem_rdata;
        state_d   = S_RMW_WR;
      end
      S_RMW_WR: begin
        mem_wr    = 1'b1;
        mem_addr  = addr_q[7:2];
        mem_wdata = merged;
        rdata_d   = 32'd0;
        state_d   = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_fault = fault_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched request registers; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      f3_q    <= 3'd0;
      addr_q  <= 8'd0;
      wdata_q <= 32'd0;
      word_q  <= 32'd0;
      rdata_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store unit that acts as the initiator for the word-wide `DataMem` array. It accepts one RV32 load or store request at a time from the execute stage through a valid/ready handshake, then drives the memory's read/write strobes, word address and write data. It performs byte/halfword extraction with sign or zero extension for loads, and read-modify-write for sub-word stores. It returns a one-cycle response pulse carrying load data or a fault flag.

## Interface
- No parameters. The memory is fixed at 64 words x 32 bits: 256-byte space, 6-bit word address.
- `clk` in 1: single clock. Every register updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE. A request is accepted when `req_valid & req_ready` at a rising edge.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32 funct3. 000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only).
- `req_addr` in 8: byte address.
- `req_wdata` in 32: store data. Only the low byte or halfword is used for B/H stores.
- `rsp_valid` out 1: one-cycle pulse marking completion.
- `rsp_rdata` out 32: load result. Holds its value until the next response.
- `rsp_fault` out 1: qualifies `rsp_valid`. Indicates an illegal or misaligned request.
- `mem_rd` out 1: drives `MemRead`.
- `mem_wr` out 1: drives `MemWrite`. The memory writes on the rising edge while `mem_wr` is high.
- `mem_addr` out 6: word address, equal to `req_addr[7:2]`.
- `mem_wdata` out 32: drives the memory `data_in`.
- `mem_rdata` in 32: from the memory `data_out`. This is a combinational read, valid in the same cycle `mem_rd` and `mem_addr` are presented.

## Operation
- States:
  - IDLE
  - LOAD
  - STORE
  - RMW_RD
  - RMW_WR
  - RESP
- State transitions:
  - IDLE goes to LOAD on an accepted legal load.
  - IDLE goes to STORE on an accepted legal SW.
  - IDLE goes to RMW_RD on an accepted legal SB/SH.
  - IDLE goes to RESP on an accepted faulting request.
  - LOAD goes to RESP.
  - STORE goes to RESP.
  - RMW_RD goes to RMW_WR.
  - RMW_WR goes to RESP.
  - RESP goes to IDLE.
- All request fields are latched at accept. Later changes on `req_*` are ignored until the next IDLE.
- `mem_rd` is 1 exactly in LOAD and RMW_RD.
- `mem_wr` is 1 exactly in STORE and RMW_WR.
- `mem_addr` and `mem_wdata` are 0 in IDLE and RESP. In all other states they come from latched values. No strobe is ever asserted outside those states.
- Load extraction, performed on the word captured at the end of LOAD:
  - LB/LBU: byte `addr[1:0]`, sign-extended for LB, zero-extended for LBU.
  - LH/LHU: halfword `addr[1]`, sign-extended for LH, zero-extended for LHU.
  - LW: the whole word.
- RMW: the word read in RMW_RD is registered. In RMW_WR, the target byte/halfword lane is replaced with `req_wdata[7:0]` or `req_wdata[15:0]`. Every other lane is preserved.
- Stores and faults return `rsp_rdata` = 0.
- The following are illegal and always fault, in any build:
  - funct3 011, 110 or 111.
  - funct3 100 or 101 with `req_we` = 1.
- Faulting requests assert no memory strobe.

## Timing
- Reset values, applied while `rst_n` = 0:
  - state = IDLE.
  - `req_ready` = 1. The accept condition is gated off during reset.
  - `rsp_valid`, `rsp_fault`, `mem_rd`, `mem_wr` = 0.
  - `rsp_rdata`, `mem_addr`, `mem_wdata` = 0.
- The accept edge is cycle 0. `rsp_valid` is high in the following cycle:
  - Load / SW: cycle 2.
  - SB / SH: cycle 3.
  - Fault: cycle 1.
- Throughput: the next accept is possible in the cycle after RESP, because `req_ready` rises then.
- `rsp_valid` is high for exactly one cycle. `rsp_fault` is only meaningful while `rsp_valid` is high, and is 0 otherwise.
- Reset mid-operation: the FSM returns to IDLE immediately and the response is dropped.
  - If reset hits in RMW_RD, no write occurs.
  - If reset hits in STORE or RMW_WR before the edge, no write occurs.

## Configuration
- `LSU_MISALIGN_FAULT_EN` defined: misaligned H accesses (`addr[0]` = 1) and W accesses (`addr[1:0]` != 0) fault.
- `LSU_MISALIGN_FAULT_EN` undefined: the offending low address bits are treated as 0, the access proceeds aligned, and no fault is raised.

## Test plan
- Reset check: hold `rst_n` = 0 for 3 cycles with `req_valid` = 1. Required: no strobes, no `rsp_valid`, all outputs at their reset values, and no accept.
- SW 0x11223344 to 0x10, then LW 0x10. Required:
  - The store shows `mem_wr` with `mem_addr` = 4 in cycle 1.
  - The load's `rsp_valid` is at cycle 2 with `rsp_rdata` = 0x11223344 and `rsp_fault` = 0.
- SB 0xAA to 0x11. Required: `rsp_valid` at cycle 3 and word 4 = 0x1122AA44. Then:
  - LB 0x11 returns 0xFFFFFFAA.
  - LBU 0x11 returns 0x000000AA.
- SH 0x8001 to 0x12. Required: word 4 = 0x8001AA44. Then:
  - LH 0x12 returns 0xFFFF8001.
  - LHU 0x12 returns 0x00008001.
- LW at 0x13. Required:
  - With the macro: `rsp_valid` and `rsp_fault` = 1 at cycle 1, and `mem_rd` never asserted.
  - Without the macro: 0x8001AA44 at cycle 2.
  - Illegal funct3 111: faults in both builds.
- Issue SB 0x55 to 0x10, then pull `rst_n` low during RMW_RD. Required: word 4 remains 0x8001AA44, no `rsp_valid`, and a subsequent LW 0x10 returns 0x8001AA44.
